// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator: 64-bit seed as key, zero IV, 1152-step warm-up, UNROLL steps per clock.
// First word registered after 1152/UNROLL + 64/UNROLL edges; no back-pressure, each valid pulse is consumed.
module trivium_keystream_gen #(
  parameter int UNROLL = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seed,
  output logic [63:0] random_out,
  output logic        random_valid
);

  localparam int WARM_EDGES = 1152 / UNROLL;
  localparam int WORD_EDGES = 64 / UNROLL;
  localparam int WCW        = (WORD_EDGES > 1) ? $clog2(WORD_EDGES) : 1;

  typedef enum logic {WARMUP, RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [287:0]      r_s;
  logic [287:0]      w_s_stepped;
  logic [10:0]       r_warm_cnt;
  logic [10:0]       w_warm_cnt_nxt;
  logic [WCW-1:0]    r_word_cnt;
  logic [WCW-1:0]    w_word_cnt_nxt;
  logic [63:0]       r_collect;
  logic [63:0]       w_collect_nxt;
  logic [63:0]       w_word;
  logic [63:0]       w_out_nxt;
  logic              w_vld_nxt;
  logic [UNROLL-1:0] w_z;

  // Bit k-1 of the vector holds Trivium state bit s_k; result is {z, next_state}.
  function automatic logic [288:0] trivium_step(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  always_comb begin : keystream_chain
    logic [288:0] step_res;
    step_res    = '0;
    w_s_stepped = r_s;
    w_z         = '0;
    for (int i = 0; i < UNROLL; i++) begin
      step_res    = trivium_step(w_s_stepped);
      w_z[i]      = step_res[288];
      w_s_stepped = step_res[287:0];
    end
  end

  // Earlier keystream bits land in lower word positions.
  always_comb begin : word_assembly
    w_word = r_collect;
    for (int j = 0; j < WORD_EDGES; j++) begin
      if (r_word_cnt == WCW'(j)) begin
        w_word[j*UNROLL +: UNROLL] = w_z;
      end
    end
  end

  always_comb begin : fsm_next
    w_state_nxt    = r_state;
    w_warm_cnt_nxt = r_warm_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_collect_nxt  = r_collect;
    w_out_nxt      = random_out;
    w_vld_nxt      = 1'b0;
    case (r_state)
      WARMUP: begin
        if (r_warm_cnt == 11'(WARM_EDGES - 1)) begin
          w_state_nxt    = RUN;
          w_warm_cnt_nxt = '0;
          w_word_cnt_nxt = '0;
        end else begin
          w_warm_cnt_nxt = r_warm_cnt + 11'd1;
        end
      end
      RUN: begin
        w_collect_nxt = w_word;
        if (r_word_cnt == WCW'(WORD_EDGES - 1)) begin
          w_word_cnt_nxt = '0;
          w_out_nxt      = w_word;
          w_vld_nxt      = 1'b1;
        end else begin
          w_word_cnt_nxt = r_word_cnt + WCW'(1);
        end
      end
      default: w_state_nxt = WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WARMUP;
      r_s          <= {3'b111, 221'd0, seed};
      r_warm_cnt   <= '0;
      r_word_cnt   <= '0;
      r_collect    <= '0;
      random_out   <= '0;
      random_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_s          <= w_s_stepped;
      r_warm_cnt   <= w_warm_cnt_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_collect    <= w_collect_nxt;
      random_out   <= w_out_nxt;
      random_valid <= w_vld_nxt;
    end
  end

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Runs every legal UNROLL side by side on shared inputs and checks each against one bit-serial Trivium model.
module tb_trivium_keystream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] seed = 64'd0;
  logic [63:0] dut_out [7];
  logic        dut_vld [7];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 7; g++) begin : g_dut
    trivium_keystream_gen #(.UNROLL(1 << g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .seed         (seed),
      .random_out   (dut_out[g]),
      .random_valid (dut_vld[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state bits s[1..288] in eSTREAM numbering, one step at a time.
  bit          ms [1:288];
  logic [63:0] exp_w [$];

  task automatic model_load(input logic [63:0] key);
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 64; i++) ms[i] = key[i-1];
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
  endtask

  task automatic model_step(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i >= 2; i--) ms[i] = ms[i-1];
    ms[1]   = t3;
    ms[94]  = t1;
    ms[178] = t2;
  endtask

  task automatic model_word(output logic [63:0] w);
    bit z;
    for (int i = 0; i < 64; i++) begin
      model_step(z);
      w[i] = z;
    end
  endtask

  task automatic model_restart(input logic [63:0] key);
    bit z;
    model_load(key);
    repeat (1152) model_step(z);
    exp_w.delete();
  endtask

  task automatic model_ensure(input int k);
    logic [63:0] w;
    while (exp_w.size() <= k) begin
      model_word(w);
      exp_w.push_back(w);
    end
  endtask

  // Scoreboard state, updated at each rising edge from the inputs seen at that edge.
  bit          started = 0;
  bit          need_reset = 0;
  logic [63:0] pend_seed;
  int          edge_cnt = 0;
  logic        exp_vld [7];
  logic [63:0] exp_out [7];
  int          first_edge [7];
  int          vld_cnt [7];

  initial begin : compare
    forever begin
      @(posedge clk);
      if (rst) begin
        started    = 1;
        need_reset = 1;
        pend_seed  = seed;
        edge_cnt   = 0;
        for (int g = 0; g < 7; g++) begin
          exp_vld[g]    = 1'b0;
          exp_out[g]    = 64'd0;
          first_edge[g] = 0;
          vld_cnt[g]    = 0;
        end
      end else if (started) begin
        if (need_reset) begin
          model_restart(pend_seed);
          need_reset = 0;
        end
        edge_cnt++;
        for (int g = 0; g < 7; g++) begin
          int per, wl, k;
          per = 64 >> g;
          wl  = 1152 / (1 << g) + per;
          if (edge_cnt >= wl && ((edge_cnt - wl) % per) == 0) begin
            k = (edge_cnt - wl) / per;
            model_ensure(k);
            exp_vld[g] = 1'b1;
            exp_out[g] = exp_w[k];
            if (first_edge[g] == 0) first_edge[g] = edge_cnt;
            vld_cnt[g]++;
          end else begin
            exp_vld[g] = 1'b0;
          end
        end
      end
      #1;
      if (started) begin
        for (int g = 0; g < 7; g++) begin
          chk($sformatf("valid_u%0d", 1 << g), {63'd0, dut_vld[g]}, {63'd0, exp_vld[g]});
          chk($sformatf("word_u%0d", 1 << g), dut_out[g], exp_out[g]);
        end
      end
    end
  end

  task automatic do_reset(input logic [63:0] s, input int n);
    rst  = 1'b1;
    seed = s;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Seed is scrambled on every non-reset cycle; it must have no effect then.
  task automatic run(input int n);
    repeat (n) begin
      seed = {$urandom, $urandom};
      @(negedge clk);
    end
  endtask

  initial begin : driver
    logic [63:0] w;
    // Raw keystream before warm-up, worked out by hand from the step equations.
    model_load(64'd0);
    model_word(w);
    chk("pin_raw_key0", w, 64'h0000_0000_0000_0007);
    model_load(64'hFFFF_FFFF_FFFF_FFFF);
    model_word(w);
    chk("pin_raw_key1s", w, 64'h0000_0000_1FFF_FFFB);

    @(negedge clk);
    do_reset(64'd0, 2);
    run(1300);
    chk("first_edge_u64_seed0", 64'(first_edge[6]), 64'd19);
    chk("first_edge_u16_seed0", 64'(first_edge[4]), 64'd76);
    chk("first_edge_u1_seed0", 64'(first_edge[0]), 64'd1216);

    do_reset(64'h0123_4567_89AB_CDEF, 1);
    run(4080);
    chk("first_edge_u16_seedA", 64'(first_edge[4]), 64'd76);
    chk("pulses_u16_seedA", 64'(vld_cnt[4]), 64'd1002);

    do_reset(64'hFFFF_FFFF_FFFF_FFFF, 1);
    run(1300);
    chk("first_edge_u1_seed1s", 64'(first_edge[0]), 64'd1216);

    do_reset({$urandom, $urandom}, 1);
    run(10);
    do_reset({$urandom, $urandom}, 1);
    run(300);
    chk("first_edge_u64_rewarm", 64'(first_edge[6]), 64'd19);

    do_reset({$urandom, $urandom}, 1);
    run(78);
    do_reset({$urandom, $urandom}, 1);
    chk("midrun_rst_vld_u16", {63'd0, dut_vld[4]}, 64'd0);
    chk("midrun_rst_out_u16", dut_out[4], 64'd0);
    run(300);
    chk("first_edge_u16_after_abort", 64'(first_edge[4]), 64'd76);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
